// File: rtl/lab4_mac_seq_pkg.sv
// Shared definitions for the lab 4 time-multiplexed three-tap summer.
// State encoding, datapath widths and default tap coefficients.
package lab4_mac_seq_pkg;

   localparam int X_W    = 10;
   localparam int FX_W   = 12;
   localparam int PROD_W = 24;
   localparam int FRAC_W = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2,
      MUL3 = 2'd3
   } state_t;

   localparam logic signed [FX_W-1:0] K1_DEF = 12'hC00;
   localparam logic signed [FX_W-1:0] K2_DEF = 12'h500;
   localparam logic signed [FX_W-1:0] K3_DEF = 12'hC00;

   // Widen a 1.9 sample to 1.11 by appending two zero fraction bits.
   function automatic logic [FX_W-1:0] widen(input logic [X_W-1:0] x);
      return {x, 2'b00};
   endfunction

endpackage

// File: rtl/lab4_mac_seq_mult.sv
// Shared 12x12 signed multiplier, purely combinational.
// Full 24-bit product; the caller picks the slice it needs.
module mult_gen_0
   import lab4_mac_seq_pkg::*;
(
   input  logic signed [FX_W-1:0]   a,
   input  logic signed [FX_W-1:0]   b,
   output logic signed [PROD_W-1:0] p
);

   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;

   // Sign-extend both operands so the product is exact in 24 bits.
   always_comb begin
      a_ext = {{(PROD_W-FX_W){a[FX_W-1]}}, a};
      b_ext = {{(PROD_W-FX_W){b[FX_W-1]}}, b};
      p     = a_ext * b_ext;
   end

endmodule

// File: rtl/lab4_mac_seq.sv
// Three-tap weighted summer, one shared multiplier, one product per clock.
// start/done handshake; y = k1*x1 + k2*x2 + k3*x3 in 1.9 signed.
module lab4_mac_seq
   import lab4_mac_seq_pkg::*;
#(
   parameter logic signed [FX_W-1:0] K1 = K1_DEF,
   parameter logic signed [FX_W-1:0] K2 = K2_DEF,
   parameter logic signed [FX_W-1:0] K3 = K3_DEF
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [X_W-1:0] x1,
   input  logic [X_W-1:0] x2,
   input  logic [X_W-1:0] x3,
   output logic           busy,
   output logic           done,
   output logic [X_W-1:0] y
);

   state_t state;

   logic [FX_W-1:0] v1;
   logic [FX_W-1:0] v2;
   logic [FX_W-1:0] v3;
   logic [FX_W-1:0] acc;

   logic signed [FX_W-1:0]   op_a;
   logic signed [FX_W-1:0]   op_b;
   logic signed [PROD_W-1:0] prod_full;
   logic [FX_W-1:0]          prod;
   logic [FX_W-1:0]          sum;
   logic                     prod_unused;

   // Select the latched sample and its coefficient for the current tap.
   always_comb begin
      op_a = '0;
      op_b = '0;
      unique case (state)
         MUL1: begin
            op_a = v1;
            op_b = K1;
         end
         MUL2: begin
            op_a = v2;
            op_b = K2;
         end
         MUL3: begin
            op_a = v3;
            op_b = K3;
         end
         default: begin
            op_a = '0;
            op_b = '0;
         end
      endcase
   end

   mult_gen_0 u_mult (
      .a (op_a),
      .b (op_b),
      .p (prod_full)
   );

   // Back to 1.11: drop the top sign bit and 11 fraction bits (floor).
   always_comb begin
      prod        = prod_full[FX_W+FRAC_W-1:FRAC_W];
      prod_unused = ^{prod_full[PROD_W-1], prod_full[FRAC_W-1:0]};
      sum         = acc + prod;
   end

   assign busy = (state != IDLE);

   // Sequencer: capture on accept, accumulate one tap per cycle, publish.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         v1    <= '0;
         v2    <= '0;
         v3    <= '0;
         acc   <= '0;
         y     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  v1    <= widen(x1);
                  v2    <= widen(x2);
                  v3    <= widen(x3);
                  acc   <= '0;
                  state <= MUL1;
               end
            end
            MUL1: begin
               acc   <= sum;
               state <= MUL2;
            end
            MUL2: begin
               acc   <= sum;
               state <= MUL3;
            end
            MUL3: begin
               acc   <= sum;
               y     <= sum[FX_W-1:2];
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lab4_mac_seq.md
# lab4_mac_seq

Time-multiplexed controller for the lab 4 three-tap weighted summer: computes y = k1·x1 + k2·x2 + k3·x3 in 1.11 signed fixed point using a single shared 12×12 signed multiplier instead of three. A start/done handshake sequences one product per clock into a 12-bit accumulator. Intended as the area-reduced drop-in for the combinational datapath, sitting between the input registers and the output display logic.

## Interface
- K1, 12'hC00, tap-1 coefficient, 1.11 signed (−0.5)
- K2, 12'h500, tap-2 coefficient, 1.11 signed (0.625)
- K3, 12'hC00, tap-3 coefficient, 1.11 signed (−0.5)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request; sampled only in IDLE
- x1, x2, x3  in  10 each  samples, 1.9 signed; captured on the accepting edge
- busy  out  1  high in MUL1..MUL3; reset 0
- done  out  1  one-cycle pulse, y valid; reset 0
- y  out  10  result, 1.9 signed, held until next done; reset 0

## Operation
- States: IDLE, MUL1, MUL2, MUL3. Reset → IDLE.
- IDLE: start=1 → latch v1..v3 = {xi, 2'b00}, acc←0, go MUL1. start=0 → stay.
- MUL1: acc←acc+p(v1,K1), go MUL2. MUL2: same with v2,K2, go MUL3.
- MUL3: y←(acc+p(v3,K3))[11:2], done←1, go IDLE.
- Product p(v,k) = t[22:11] of 24-bit signed t = v·k (floor toward −∞; t[23] discarded).
- Accumulator 12-bit signed, two's-complement wrap on overflow, no saturation; wrap order does not affect result.
- start while busy ignored; x changes while busy ignored (latched copies used).
- done is a registered pulse; deasserts the following cycle unless a new result completes.
- reset asserted mid-operation: state→IDLE, busy/done/y→0, in-flight result discarded.

## Timing
- Accepting edge E0 (IDLE, start=1). MUL1 at E1, MUL2 at E2, MUL3 at E3.
- done=1 and new y visible after E3 for exactly one cycle; busy high between E0 and E3.
- Latency start→done: 3 cycles after accepting edge. Next start accepted at E4 earliest; throughput one result per 4 cycles with start held high.
- Multiplier combinational; path mux→multiplier→adder→acc in one cycle.

## Structure
- Shared package: state encoding enum (IDLE/MUL1/MUL2/MUL3), default coefficient constants, widths (X_W=10, FX_W=12, PROD_W=24).
- One sub-module: mult_gen_0 (12×12 signed → 24, combinational), instanced once; operand muxes and product slicing in the controller.

## Test plan
- x1=x2=x3=10'h100, pulse start → done after 3 cycles, y=10'h3A0 (acc 12'hE80, −0.1875).
- All x=0 → y=10'h000; then x2=10'h1FF, x1=x3=0 → y=10'h13F (p2=12'h4FD, truncation).
- x1=10'h001, others 0 → y=10'h3FF (p1=12'hFFE, negative floor).
- x1=x3=10'h200, x2=10'h200 → y=10'h0C0; start held high continuously → done every 4th cycle, busy pattern 1,1,1,0.
- Start accepted, change x and re-pulse start during MUL2 → result uses original x, second start ignored.
- Assert reset during MUL2 → busy/done/y=0 immediately, state IDLE; next start yields correct result.
